// File: rtl/spi_reg_config.sv
// spi_reg_config: SPI mode-0 target holding the PWM peripheral configuration
// registers (output enables, PWM enables, duty cycle).
//
// Each frame is 16 bits, MSB first: R/W (1 = write), 7-bit address, 8-bit data.
// A register is updated only by a complete, well-formed write frame that is
// closed by ncs rising.
//
// Optional feature: define SPI_READBACK_EN to enable register readback on
// cipo during read frames. Without it cipo is tied low and reads are ignored.
module spi_reg_config #(
  parameter int SYNC_STAGES = 2,  // synchronizer depth, 2..3
  parameter int MAX_ADDR    = 4   // highest implemented register address
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update
);

  localparam int NUM_REGS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_dly_q;
  logic                   ncs_dly_q;

  // Synchronize the three SPI pins; idle values are sclk=0, ncs=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;      // received bits, saturates at 16
  logic [15:0] shift_q, shift_d;  // received frame, LSB is the latest bit
  logic        ovf_q, ovf_d;      // a 17th sclk edge arrived: frame too long

  // Sequencer state and frame capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: shift bits in CMD/DATA, close the frame on ncs rising.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        // sclk activity with ncs high is ignored here
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (ncs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
        end
      end

      CMD: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) state_d = DATA;
        end
      end

      DATA: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          if (cnt_q == 5'd16) begin
            // Counter saturates; remember the overrun so the frame is dropped.
            ovf_d = 1'b1;
          end else begin
            shift_d = {shift_q[14:0], copi_s};
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end

      COMMIT: begin
        // A new frame starting during COMMIT goes straight to CMD.
        if (ncs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Commit decision and register file
  // --------------------------------------------------------------------------
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       write_ok;

  assign wr_addr  = shift_q[14:8];
  assign wr_data  = shift_q[7:0];
  assign write_ok = (state_q == COMMIT) && (cnt_q == 5'd16) && !ovf_q &&
                    shift_q[15] && (wr_addr <= 7'(MAX_ADDR));

  assign cfg_update = write_ok;

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  // Select which register, if any, takes the committed data byte.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (write_ok && (wr_addr == 7'(i))) regs_d[i] = wr_data;
    end
  end

  // Configuration register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this small register file drives configuration pins directly,
      // so it must come out of reset at a known value and is reset per entry;
      // a true RAM would not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

  // --------------------------------------------------------------------------
  // Readback (optional)
  // --------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic       rd_ok;
  logic [7:0] rd_val;
  logic [7:0] tx_q, tx_d;
  logic       rd_active_q, rd_active_d;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  // Address and R/W as they stand once the 8th bit is shifted in.
  assign rd_addr = {shift_q[5:0], copi_s};
  assign rd_ok   = !shift_q[6] && (rd_addr <= 7'(MAX_ADDR));

  // Read mux; implemented-but-unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) rd_val = regs_q[i];
    end
  end

  // Load the transmit byte on the 8th rising edge, shift on later falls.
  always_comb begin
    tx_d        = tx_q;
    rd_active_d = rd_active_q;
    if (state_q == CMD && !ncs_rise && sclk_rise && cnt_q == 5'd7) begin
      tx_d        = rd_ok ? rd_val : 8'h00;
      rd_active_d = rd_ok;
    end else if (state_q == DATA && sclk_fall && cnt_q >= 5'd9) begin
      // The falling edge right after the load (cnt==8) is skipped so the
      // MSB is still on cipo when the controller samples bit 7.
      tx_d = {tx_q[6:0], 1'b0};
    end else if (state_q == COMMIT || state_q == IDLE) begin
      rd_active_d = 1'b0;
    end
  end

  // Readback shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q        <= '0;
      rd_active_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      rd_active_q <= rd_active_d;
    end
  end

  assign cipo = (state_q == DATA) && rd_active_q && tx_q[7];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_config.sv
// Directed bench for spi_reg_config: bit-bangs SPI frames at 1/12 of clk and
// checks the register outputs, the cfg_update pulse count and cipo.
module tb_spi_reg_config;

  localparam time CLK_HALF  = 5ns;
  localparam time SCLK_HALF = 60ns;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, copi, ncs;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       cfg_update;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cipo_high = 0;

  spi_reg_config #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .cipo           (cipo),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .cfg_update     (cfg_update)
  );

  always #(CLK_HALF) clk = ~clk;

  // Count commit pulses and any cipo activity, sampled away from the edge.
  always @(negedge clk) begin
    if (cfg_update === 1'b1) pulses++;
    if (cipo !== 1'b0) cipo_high++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, ".out_7_0"},  en_reg_out_7_0,  e0);
    check({tag, ".out_15_8"}, en_reg_out_15_8, e1);
    check({tag, ".pwm_7_0"},  en_reg_pwm_7_0,  e2);
    check({tag, ".pwm_15_8"}, en_reg_pwm_15_8, e3);
    check({tag, ".duty"},     pwm_duty_cycle,  e4);
  endtask

  // Send nbits of val MSB first. cipo is sampled just before each of the
  // last 8 rising edges. If rst_after >= 0, reset is pulsed after that many
  // bits and the frame is then closed.
  task automatic spi_xfer(input logic [31:0] val, input int nbits, input int rst_after,
                          output logic [7:0] rx);
    int sent = 0;
    rx = '0;
    @(posedge clk); #2;
    ncs = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = val[i];
      #(SCLK_HALF);
      if (i < 8) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      #(SCLK_HALF);
      sclk = 1'b0;
      sent++;
      if (rst_after >= 0 && sent == rst_after) begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #2 ncs = 1'b1;
    copi = 1'b0;
    repeat (12) @(posedge clk);
    #2;
  endtask

  logic [7:0] rx;
  int         p0;

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Reset state
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset.cfg_update", cfg_update, 1'b0);
    check("reset.cipo", cipo, 1'b0);

    // Write address 0 then address 4
    p0 = pulses;
    spi_xfer(32'h80F0, 16, -1, rx);
    check("wr00.pulses", pulses - p0, 1);
    check_regs("wr00", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

    p0 = pulses;
    spi_xfer(32'h84AA, 16, -1, rx);
    check("wr04.pulses", pulses - p0, 1);
    check_regs("wr04", 8'hF0, 8'h00, 8'h00, 8'h00, 8'hAA);

    // Address above MAX_ADDR is discarded
    p0 = pulses;
    spi_xfer(32'h85FF, 16, -1, rx);
    check("wr05.pulses", pulses - p0, 0);
    check_regs("wr05", 8'hF0, 8'h00, 8'h00, 8'h00, 8'hAA);

    // Give address 2 a known value, then try short and long frames at it
    p0 = pulses;
    spi_xfer(32'h8234, 16, -1, rx);
    check("wr02.pulses", pulses - p0, 1);
    check("wr02.pwm_7_0", en_reg_pwm_7_0, 8'h34);

    p0 = pulses;
    spi_xfer(32'h821, 12, -1, rx);         // first 12 bits of 0x8212
    check("short.pulses", pulses - p0, 0);
    check("short.pwm_7_0", en_reg_pwm_7_0, 8'h34);

    p0 = pulses;
    spi_xfer(32'h10425, 17, -1, rx);       // 0x8212 followed by an extra 1
    check("long.pulses", pulses - p0, 0);
    check("long.pwm_7_0", en_reg_pwm_7_0, 8'h34);

    // Reset after 10 bits of a write to address 3 clears everything
    p0 = pulses;
    spi_xfer(32'h8312, 16, 10, rx);
    check("rstmid.pulses", pulses - p0, 0);
    check_regs("rstmid", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    p0 = pulses;
    spi_xfer(32'h8312, 16, -1, rx);
    check("wr03.pulses", pulses - p0, 1);
    check_regs("wr03", 8'h00, 8'h00, 8'h00, 8'h12, 8'h00);

    // Readback of address 3
    spi_xfer(32'h8355, 16, -1, rx);
    check("wr03b.pwm_15_8", en_reg_pwm_15_8, 8'h55);

    p0 = pulses;
    cipo_high = 0;
    spi_xfer(32'h0300, 16, -1, rx);
    check("rd03.pulses", pulses - p0, 0);
`ifdef SPI_READBACK_EN
    check("rd03.cipo_byte", rx, 8'h55);
`else
    check("rd03.cipo_byte", rx, 8'h00);
    check("rd03.cipo_idle", cipo_high, 0);
`endif
    check_regs("rd03", 8'h00, 8'h00, 8'h00, 8'h55, 8'h00);
    check("end.cipo", cipo, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
